systolic_seq_ctrl: RTL

Sequencer that owns one N×N bit-serial systolic array (AND-accumulate, OR/XOR reduce) and turns it into a command-driven outer-product accumulator. It clears the array, streams K operand vector pairs into the array edges with the required diagonal skew, flushes the pipeline, and drains the N result rows through a ready/valid output port. It sits between the top-level I/O unpacking logic and the array instance. After an array reset, all array control comes from this block.

---
 rtl/systolic_seq_ctrl_pkg.sv | 20 ++
 rtl/systolic_seq_ctrl_skew_line.sv | 35 +++
 rtl/systolic_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FLUSH,
    S_DRAIN
  } state_t;

  localparam int N_DEFAULT    = 8;
  // Cycles needed for the last beat to reach the far corner cell (i+j = 2N-2).
  localparam int FLUSH_CYCLES = 2 * N_DEFAULT - 2;

  function automatic int flush_cycles(input int n);
    return 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// One operand lane delay line: DEPTH valid-beats of delay, advancing only on en.
module skew_line
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage delay.
      always_ff @(posedge clk) begin
        if (reset || clear) sr <= '0;
        else if (en)        sr <= d;
      end
    end else begin : g_many
      // Multi-stage shift toward the output end.
      always_ff @(posedge clk) begin
        if (reset || clear) sr <= '0;
        else if (en)        sr <= {sr[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Command-driven sequencer for an NxN bit-serial systolic outer-product array.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_CLEAR | one cycle of array/skew reset
// S_LOAD  | accepting K operand beats
// S_FLUSH | 2N-2 zero beats to push the last data through
// S_DRAIN | prime cycle, then N result rows from N-1 down to 0
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N    = 8,
  parameter int LENW = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LENW-1:0]             len,
  input  logic                        mode_xor,
  output logic                        busy,
  output logic                        done,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [N-1:0]                op_a,
  input  logic [N-1:0]                op_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [N-1:0]                res_data,
  output logic [$clog2(N)-1:0]        res_row,
  output logic                        arr_reset,
  output logic                        arr_valid,
  output logic                        arr_readout,
  output logic                        arr_xor,
  output logic [N-1:0]                arr_in1,
  output logic [N-1:0]                arr_in2,
  input  logic [N-1:0]                arr_out
);

  localparam int RW        = $clog2(N);
  localparam int FLUSH_CYC = flush_cycles(N);
  localparam int FW        = $clog2(FLUSH_CYC + 1);

  state_t          state;
  logic [LENW-1:0] beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            arr_reset_q;
  logic            flush_q;
  logic            prime_q;

  logic            op_fire;
  logic            res_fire;
  logic            last_row;
  logic [N-1:0]    a_feed;
  logic [N-1:0]    b_feed;

  assign op_fire     = op_valid & op_ready;
  assign res_fire    = res_valid & res_ready;
  assign last_row    = (res_row == '0);
  assign done        = res_fire & last_row & ~reset;
  // LOAD beats, FLUSH beats and readouts live in different states, so never overlap.
  assign arr_valid   = op_fire | flush_q;
  assign arr_readout = prime_q | (res_fire & ~last_row);
  assign arr_reset   = reset | arr_reset_q;
  assign res_data    = arr_out;
  // Zero is fed whenever no operand is accepted, which covers the flush beats.
  assign a_feed      = op_fire ? op_a : '0;
  assign b_feed      = op_fire ? op_b : '0;

  assign arr_in1[0] = a_feed[0];
  assign arr_in2[0] = b_feed[0];

  generate
    for (genvar k = 1; k < N; k++) begin : g_skew
      skew_line #(.DEPTH(k)) u_skew_a (
        .clk  (clk),
        .reset(reset),
        .clear(arr_reset_q),
        .en   (arr_valid),
        .d    (a_feed[k]),
        .q    (arr_in1[k])
      );
      skew_line #(.DEPTH(k)) u_skew_b (
        .clk  (clk),
        .reset(reset),
        .clear(arr_reset_q),
        .en   (arr_valid),
        .d    (b_feed[k]),
        .q    (arr_in2[k])
      );
    end
  endgenerate

  // Sequencer FSM with registered state-derived outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      res_row     <= '0;
      arr_xor     <= 1'b0;
      busy        <= 1'b0;
      op_ready    <= 1'b0;
      res_valid   <= 1'b0;
      arr_reset_q <= 1'b0;
      flush_q     <= 1'b0;
      prime_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_CLEAR;
            beat_cnt    <= len;
            arr_xor     <= mode_xor;
            arr_reset_q <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_CLEAR: begin
          arr_reset_q <= 1'b0;
          if (beat_cnt != '0) begin
            state    <= S_LOAD;
            op_ready <= 1'b1;
          end else begin
            state     <= S_FLUSH;
            flush_q   <= 1'b1;
            flush_cnt <= FW'(FLUSH_CYC - 1);
          end
        end
        S_LOAD: begin
          if (op_fire) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == LENW'(1)) begin
              state     <= S_FLUSH;
              op_ready  <= 1'b0;
              flush_q   <= 1'b1;
              flush_cnt <= FW'(FLUSH_CYC - 1);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= S_DRAIN;
            flush_q <= 1'b0;
            prime_q <= 1'b1;
            res_row <= RW'(N - 1);
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (prime_q) begin
            prime_q   <= 1'b0;
            res_valid <= 1'b1;
          end else if (res_fire) begin
            if (last_row) begin
              state     <= S_IDLE;
              res_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              res_row <= res_row - 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
